// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg -- constants and types shared by the fetch stage and the
// decoder that consumes its IF/ID outputs.
//   XLEN          : datapath width
//   NOP_INSTR     : canonical RV32I NOP (addi x0, x0, 0)
//   OPC_*         : major opcodes seen by the opcode decoder
//   fetch_state_e : fetch FSM states
//   pc_sel_e      : next-pc mux select for pc_register
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  typedef enum logic {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INCR     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// pc_register -- program counter with async reset to RESET_VECTOR and a
// three-way next-pc mux (hold, +4, redirect target).
//   clk, rst_n   : clock, asynchronous active-low reset
//   pc_sel       : next-pc source
//   redirect_pc  : redirect target (aligned here)
//   pc           : current fetch address
//   pc_plus4     : pc + 4, modulo 2^32
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_e         pc_sel,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Wraps silently from 32'hFFFF_FFFC to 0.
  assign pc_plus4 = pc_q + 32'd4;
  assign pc       = pc_q;

  always_comb begin
    unique case (pc_sel)
      PC_INCR:     pc_d = pc_plus4;
      PC_REDIRECT: pc_d = align_word(redirect_pc);
      default:     pc_d = pc_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_VECTOR;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- single-outstanding-request instruction fetch feeding the
// IF/ID register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_req, imem_addr : request pulse / address (address always equals pc)
//   imem_rvalid, _rdata : one response per request, at least a cycle later
//   stall_d             : decode cannot accept; hold IF/ID
//   redirect, _pc       : taken control transfer from execute (top priority)
//   instr_d, pc_d,
//   pc_plus4_d, valid_d : IF/ID register contents
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_d,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  fetch_state_e    state_q, state_d;
  logic            squash_q, squash_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic            ifid_valid_q, ifid_valid_d;

  logic            issue;
  logic            rsp;
  logic            capture;
  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;

  pc_register #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_register (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  // A new request may go out only when IF/ID will have room for its response:
  // either it is empty or decode is draining it this very cycle.
  assign issue     = (state_q == ISSUE) && !redirect && (!ifid_valid_q || !stall_d);
  assign rsp       = (state_q == WAIT) && imem_rvalid;
  assign capture   = rsp && !squash_q && !redirect;

  assign imem_req  = issue;
  assign imem_addr = pc;

  assign instr_d    = ifid_instr_q;
  assign pc_d       = ifid_pc_q;
  assign pc_plus4_d = ifid_pc4_q;
  assign valid_d    = ifid_valid_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    state_d      = state_q;
    squash_d     = squash_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    pc_sel       = PC_HOLD;

    if (capture) begin
      ifid_instr_d = imem_rdata;
      ifid_pc_d    = pc;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
      pc_sel       = PC_INCR;
    end else if (ifid_valid_q && !stall_d) begin
      ifid_valid_d = 1'b0;
    end

    unique case (state_q)
      ISSUE: begin
        if (issue) state_d = WAIT;
      end
      WAIT: begin
        if (rsp) begin
          // Response retires the outstanding request whether kept or dropped.
          state_d  = ISSUE;
          squash_d = 1'b0;
        end else if (redirect) begin
          // The in-flight response belongs to the old path; drop it on arrival.
          squash_d = 1'b1;
        end
      end
      default: state_d = ISSUE;
    endcase

    // Redirect wins over everything, including a decode stall.
    if (redirect) begin
      pc_sel       = PC_REDIRECT;
      ifid_valid_d = 1'b0;
    end
  end

  // NOTE: the IF/ID payload is reset to a NOP rather than left undefined so
  // the decoder never sees X on a bubble straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ISSUE;
      squash_q     <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      squash_q     <= squash_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- directed, cycle-by-cycle bench for fetch_stage.
// Each record gives the inputs for one cycle and the outputs expected during
// that cycle (before the closing rising edge). Inputs are driven on the
// falling edge and outputs sampled 1 ns later.
module tb_fetch_stage;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tbl [20];

  fetch_stage #(
    .RESET_VECTOR (RV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall_d     (stall_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic rv, input logic [31:0] rdat,
                             input logic er, input logic [31:0] ea, input logic ev,
                             input logic [31:0] ei, input logic [31:0] ep,
                             input logic [31:0] ep4);
    vec_t r;
    r.stall = st;  r.redir = rd;  r.rpc = rpc;  r.rvalid = rv;  r.rdata = rdat;
    r.e_req = er;  r.e_addr = ea; r.e_valid = ev;
    r.e_instr = ei; r.e_pc = ep;  r.e_pc4 = ep4;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall_d     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".addr"},  imem_addr,  RV);
    check({tag, ".valid"}, {31'd0, valid_d}, 32'd0);
    check({tag, ".instr"}, instr_d,    32'h0000_0013);
    check({tag, ".pc_d"},  pc_d,       32'h0);
    check({tag, ".pc4"},   pc_plus4_d, 32'h0);
  endtask

  task automatic apply(input string tag, input vec_t t);
    @(negedge clk);
    stall_d     = t.stall;
    redirect    = t.redir;
    redirect_pc = t.rpc;
    imem_rvalid = t.rvalid;
    imem_rdata  = t.rdata;
    #1;
    check({tag, ".req"},   {31'd0, imem_req}, {31'd0, t.e_req});
    check({tag, ".addr"},  imem_addr,         t.e_addr);
    check({tag, ".valid"}, {31'd0, valid_d},  {31'd0, t.e_valid});
    check({tag, ".instr"}, instr_d,           t.e_instr);
    check({tag, ".pc_d"},  pc_d,              t.e_pc);
    check({tag, ".pc4"},   pc_plus4_d,        t.e_pc4);
  endtask

  initial begin
    //              st rd rpc            rv rdata          req addr        vld instr          pc_d           pc4
    // Basic fetch from reset with a 1-cycle memory.
    tbl[0]  = v(0, 0, 32'h0,         0, 32'h0,         1, 32'h1000,     0, 32'h0000_0013, 32'h0,         32'h0);
    tbl[1]  = v(0, 0, 32'h0,         1, 32'h0000_0003, 0, 32'h1000,     0, 32'h0000_0013, 32'h0,         32'h0);
    // Five-cycle stall with valid_d high; a stray rvalid in ISSUE is ignored.
    tbl[2]  = v(1, 0, 32'h0,         0, 32'h0,         0, 32'h1004,     1, 32'h0000_0003, 32'h1000,      32'h1004);
    tbl[3]  = v(1, 0, 32'h0,         0, 32'h0,         0, 32'h1004,     1, 32'h0000_0003, 32'h1000,      32'h1004);
    tbl[4]  = v(1, 0, 32'h0,         1, 32'hDEAD_0000, 0, 32'h1004,     1, 32'h0000_0003, 32'h1000,      32'h1004);
    tbl[5]  = v(1, 0, 32'h0,         0, 32'h0,         0, 32'h1004,     1, 32'h0000_0003, 32'h1000,      32'h1004);
    tbl[6]  = v(1, 0, 32'h0,         0, 32'h0,         0, 32'h1004,     1, 32'h0000_0003, 32'h1000,      32'h1004);
    // Stall drops: fetch resumes the same cycle and the entry is consumed.
    tbl[7]  = v(0, 0, 32'h0,         0, 32'h0,         1, 32'h1004,     1, 32'h0000_0003, 32'h1000,      32'h1004);
    tbl[8]  = v(0, 0, 32'h0,         1, 32'h00A0_0093, 0, 32'h1004,     0, 32'h0000_0003, 32'h1000,      32'h1004);
    // 2-cycle memory.
    tbl[9]  = v(0, 0, 32'h0,         0, 32'h0,         1, 32'h1008,     1, 32'h00A0_0093, 32'h1004,      32'h1008);
    tbl[10] = v(0, 0, 32'h0,         0, 32'h0,         0, 32'h1008,     0, 32'h00A0_0093, 32'h1004,      32'h1008);
    tbl[11] = v(0, 0, 32'h0,         1, 32'h1234_5678, 0, 32'h1008,     0, 32'h00A0_0093, 32'h1004,      32'h1008);
    // Redirect in ISSUE to an unaligned target: no request, pc aligned.
    tbl[12] = v(0, 1, 32'h0000_0203, 0, 32'h0,         0, 32'h100C,     1, 32'h1234_5678, 32'h1008,      32'h100C);
    tbl[13] = v(0, 0, 32'h0,         0, 32'h0,         1, 32'h0200,     0, 32'h1234_5678, 32'h1008,      32'h100C);
    tbl[14] = v(0, 0, 32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0200,     0, 32'h1234_5678, 32'h1008,      32'h100C);
    // Redirect overrides an active stall and kills the held entry.
    tbl[15] = v(1, 1, 32'h0000_0300, 0, 32'h0,         0, 32'h0204,     1, 32'hDEAD_BEEF, 32'h0200,      32'h0204);
    // Stall with empty IF/ID still fetches.
    tbl[16] = v(1, 0, 32'h0,         0, 32'h0,         1, 32'h0300,     0, 32'hDEAD_BEEF, 32'h0200,      32'h0204);
    tbl[17] = v(1, 0, 32'h0,         1, 32'h0000_0513, 0, 32'h0300,     0, 32'hDEAD_BEEF, 32'h0200,      32'h0204);
    tbl[18] = v(1, 0, 32'h0,         0, 32'h0,         0, 32'h0304,     1, 32'h0000_0513, 32'h0300,      32'h0304);
    tbl[19] = v(0, 0, 32'h0,         0, 32'h0,         1, 32'h0304,     1, 32'h0000_0513, 32'h0300,      32'h0304);

    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    #1 check_reset_values("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

    // Redirect while WAIT (request at 0x304 in flight), response 3 cycles late.
    apply("late_redir",  v(0, 1, 32'h0000_0200, 0, 32'h0,         0, 32'h0304, 0, 32'h0000_0513, 32'h0300, 32'h0304));
    apply("late_wait1",  v(0, 0, 32'h0,         0, 32'h0,         0, 32'h0200, 0, 32'h0000_0513, 32'h0300, 32'h0304));
    apply("late_wait2",  v(0, 0, 32'h0,         0, 32'h0,         0, 32'h0200, 0, 32'h0000_0513, 32'h0300, 32'h0304));
    apply("late_drop",   v(0, 0, 32'h0,         1, 32'hBAD0_BAD0, 0, 32'h0200, 0, 32'h0000_0513, 32'h0300, 32'h0304));
    apply("late_issue",  v(0, 0, 32'h0,         0, 32'h0,         1, 32'h0200, 0, 32'h0000_0513, 32'h0300, 32'h0304));
    apply("late_rsp",    v(0, 0, 32'h0,         1, 32'h0010_0113, 0, 32'h0200, 0, 32'h0000_0513, 32'h0300, 32'h0304));
    apply("late_cap",    v(0, 0, 32'h0,         0, 32'h0,         1, 32'h0204, 1, 32'h0010_0113, 32'h0200, 32'h0204));

    // Redirect coincident with rvalid: response dropped, squash stays clear,
    // so the very next response is captured.
    apply("coin_redir",  v(0, 1, 32'h0000_0402, 1, 32'hFEED_FACE, 0, 32'h0204, 0, 32'h0010_0113, 32'h0200, 32'h0204));
    apply("coin_issue",  v(0, 0, 32'h0,         0, 32'h0,         1, 32'h0400, 0, 32'h0010_0113, 32'h0200, 32'h0204));
    apply("coin_rsp",    v(0, 0, 32'h0,         1, 32'h0000_0063, 0, 32'h0400, 0, 32'h0010_0113, 32'h0200, 32'h0204));
    apply("coin_cap",    v(0, 0, 32'h0,         0, 32'h0,         1, 32'h0404, 1, 32'h0000_0063, 32'h0400, 32'h0404));

    // Address wrap at the top of the address space.
    apply("wrap_redir",  v(0, 1, 32'hFFFF_FFFF, 1, 32'h0,         0, 32'h0404, 0, 32'h0000_0063, 32'h0400, 32'h0404));
    apply("wrap_issue",  v(0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0000_0063, 32'h0400, 32'h0404));
    apply("wrap_rsp",    v(0, 0, 32'h0,         1, 32'h0000_006F, 0, 32'hFFFF_FFFC, 0, 32'h0000_0063, 32'h0400, 32'h0404));
    apply("wrap_cap",    v(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0000, 1, 32'h0000_006F, 32'hFFFF_FFFC, 32'h0000_0000));

    // Reset pulsed while WAIT (request at 0x0 in flight), then a stray rvalid.
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1 check_reset_values("midrst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    apply("rst_stray",   v(0, 0, 32'h0,         1, 32'hBADB_ADBB, 1, RV,         0, 32'h0000_0013, 32'h0,    32'h0));
    apply("rst_rsp",     v(0, 0, 32'h0,         1, 32'h0000_0033, 0, RV,         0, 32'h0000_0013, 32'h0,    32'h0));
    apply("rst_cap",     v(0, 0, 32'h0,         0, 32'h0,         1, 32'h1004,   1, 32'h0000_0033, 32'h1000, 32'h1004));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter: RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 imem_req  out  1  one-cycle request pulse to instruction memory.
REQ-006 imem_addr  out  32  fetch address; equals pc at all times.
REQ-007 imem_rvalid  in  1  response valid; at least 1 cycle after imem_req, one response per request.
REQ-008 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-009 stall_d  in  1  decode cannot accept; hold IF/ID contents.
REQ-010 redirect  in  1  taken branch/jump/jalr from execute.
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 instr_d  out  32  IF/ID instruction, feeding the opcode decoder.
REQ-013 pc_d  out  32  address of instr_d.
REQ-014 pc_plus4_d  out  32  pc_d + 4, for the jal/jalr link value.
REQ-015 valid_d  out  1  instr_d is a live instruction.

Function
REQ-016 FSM states: ISSUE and WAIT. Reset state is ISSUE.
REQ-017 ISSUE: imem_req = 1 when !redirect && (!valid_d || !stall_d). The same cycle moves to WAIT. Otherwise the block stays in ISSUE with imem_req = 0.
REQ-018 WAIT: imem_req = 0, and pc is held stable.
REQ-019 WAIT with imem_rvalid, squash = 0 and no redirect:
  - instr_d <= imem_rdata; pc_d <= pc; pc_plus4_d <= pc + 4; valid_d <= 1.
  - pc <= pc + 4; next state ISSUE.
REQ-020 WAIT with imem_rvalid and squash = 1: discard the response, clear squash, go to ISSUE, leave pc unchanged.
REQ-021 Consumption: when valid_d && !stall_d and no new capture occurs, valid_d <= 0.
REQ-022 stall_d with valid_d = 1: instr_d, pc_d, pc_plus4_d and valid_d are held unchanged.
REQ-023 Redirect has the highest priority and overrides stall_d. In any state it sets pc <= {redirect_pc[31:2], 2'b00} and valid_d <= 0.
REQ-024 Redirect in WAIT without imem_rvalid: set squash and stay in WAIT.
REQ-025 Redirect in WAIT with imem_rvalid in the same cycle: discard the response, leave squash clear, go to ISSUE.
REQ-026 Redirect in ISSUE: no request is issued that cycle; stay in ISSUE.
REQ-027 imem_rvalid is ignored in ISSUE.
REQ-028 At most one memory request is outstanding at any time.
REQ-029 Throughput is one instruction per 2 cycles with 1-cycle memory.
REQ-030 Latency: a request at cycle N with rvalid at N+1 gives valid_d = 1 at N+2.
REQ-031 All address arithmetic is modulo 2^32: pc 32'hFFFF_FFFC increments to 32'h0000_0000 with no flag.
REQ-032 imem_rdata is passed through unmodified; the block performs no decode.

Reset
REQ-033 On rst_n low, asynchronously:
  - pc = RESET_VECTOR; state = ISSUE; squash = 0; valid_d = 0.
  - instr_d = 32'h0000_0013 (NOP); pc_d = 0; pc_plus4_d = 0.
REQ-034 Reset asserted mid-WAIT abandons the outstanding request. A stale imem_rvalid after reset release is ignored per REQ-027.
REQ-035 The first imem_req occurs in the first cycle after rst_n deasserts.

Structure
REQ-036 The following belong in the shared constants package beside the opcode constants:
  - XLEN = 32.
  - NOP_INSTR = 32'h0000_0013.
  - Fetch-state enum {ISSUE, WAIT}.
REQ-037 One sub-module, pc_register, SHALL hold pc with async reset to RESET_VECTOR and next-pc mux inputs (increment, redirect, hold).

Verification
REQ-038 Reset release, RESET_VECTOR = 32'h0000_1000, 1-cycle memory returning 32'h0000_0003 -> expected:
  - imem_addr sequence 0x1000, 0x1004.
  - valid_d = 1 at cycle 2 with instr_d = 32'h0000_0003, pc_d = 0x1000, pc_plus4_d = 0x1004.
REQ-039 stall_d held high 5 cycles while valid_d = 1 -> IF/ID outputs are unchanged, no imem_req is issued, and fetch resumes the cycle stall_d drops.
REQ-040 Redirect to 32'h0000_0200 while WAIT, response 3 cycles late -> expected:
  - The late response is discarded and valid_d stays 0.
  - The next imem_addr = 0x200, and the captured pc_d = 0x200.
REQ-041 Redirect coincident with imem_rvalid, redirect_pc = 32'h0000_0402 -> response dropped, pc = 0x400, squash remains 0.
REQ-042 pc at 32'hFFFF_FFFC fetches successfully -> pc_plus4_d = 0 and the next imem_addr = 0.
REQ-043 rst_n pulsed low during WAIT, then a stray imem_rvalid -> outputs are at reset values, the stray response is ignored, and the first fetch is at RESET_VECTOR.
